// File: rtl/led_ctrl_pkg.sv
// Shared types, constants and the round-constant update for the LED round controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam int          ROUNDS_64  = 32;
  localparam int          ROUNDS_128 = 48;
  localparam logic [5:0]  RC_INIT    = 6'h01;

  // LED round-constant LFSR step: shift left, feed back XNOR of the two top bits.
  function automatic logic [5:0] rc_next(input logic [5:0] cur);
    return {cur[4:0], ~(cur[5] ^ cur[4])};
  endfunction

endpackage

// File: rtl/led_rc_lfsr.sv
// 6-bit LED round-constant generator; init reloads the seed, en advances one round.
module led_rc_lfsr
  import led_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       en,
  output logic [5:0] rc
);

  logic [5:0] rc_q;
  logic [5:0] rc_d;

  always_comb begin
    rc_d = rc_q;
    if (init) begin
      rc_d = RC_INIT;
    end else if (en) begin
      rc_d = rc_next(rc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q <= RC_INIT;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc = rc_q;

endmodule

// File: rtl/led_round_ctrl.sv
// Round controller for masked LED-64/LED-128 with a multi-stage S-box datapath.
// Optional abort input enabled by defining LED_CTRL_ABORT_EN.
module led_round_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int SBOX_STAGES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key128,
`ifdef LED_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       load,
  output logic       busy,
  output logic       add_key,
  output logic       sel_key,
  output logic       round_en,
  output logic [5:0] rc,
  output logic [5:0] round_cnt,
  output logic       done
);

  localparam int              PH_W    = (SBOX_STAGES > 1) ? $clog2(SBOX_STAGES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SBOX_STAGES - 1);

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [5:0]      round_q, round_d;
  logic            mode_q,  mode_d;
  logic            done_q,  done_d;

  logic            abort_w;
  logic            phase_last;
  logic [5:0]      round_last;
  logic            rc_init;
  logic            rc_en;

`ifdef LED_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign phase_last = (phase_q == PH_LAST);
  assign round_last = mode_q ? 6'(ROUNDS_128 - 1) : 6'(ROUNDS_64 - 1);

  // Next-state and strobe generation; the phase counter sub-divides each round
  // into one cycle per S-box register stage.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    round_d  = round_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    load     = 1'b0;
    add_key  = 1'b0;
    sel_key  = 1'b0;
    round_en = 1'b0;
    rc_init  = 1'b0;
    rc_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          mode_d  = key128;
          round_d = '0;
          phase_d = '0;
          rc_init = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        round_en = phase_last;
        add_key  = (phase_q == '0) && (round_q[1:0] == 2'b00);
        sel_key  = mode_q & round_q[2];
        if (abort_w) begin
          state_d = IDLE;
        end else if (phase_last) begin
          phase_d = '0;
          round_d = round_q + 6'd1;
          rc_en   = 1'b1;
          if (round_q == round_last) begin
            state_d = FINAL;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      FINAL: begin
        // Final whitening always uses K1.
        add_key = 1'b1;
        state_d = IDLE;
        done_d  = ~abort_w;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  led_rc_lfsr u_rc_lfsr (
    .clk  (clk),
    .rst  (rst),
    .init (rc_init),
    .en   (rc_en),
    .rc   (rc)
  );

  assign busy      = (state_q != IDLE);
  assign round_cnt = round_q;
  assign done      = done_q;

endmodule

// File: tb/tb_led_round_ctrl.sv
// Directed self-checking bench for led_round_ctrl (S=5 and S=1 instances).
module tb_led_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start5, key5, start1, key1;
  logic       load5, busy5, add5, sel5, ren5, done5;
  logic       load1, busy1, add1, sel1, ren1, done1;
  logic [5:0] rc5, rcnt5, rc1, rcnt1;
`ifdef LED_CTRL_ABORT_EN
  logic       abort5, abort1;
`endif

  int total  = 0;
  int passed = 0;

  logic [5:0] rc_trace [8] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};

  led_round_ctrl #(.SBOX_STAGES(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .key128(key5),
`ifdef LED_CTRL_ABORT_EN
    .abort(abort5),
`endif
    .load(load5), .busy(busy5), .add_key(add5), .sel_key(sel5),
    .round_en(ren5), .rc(rc5), .round_cnt(rcnt5), .done(done5)
  );

  led_round_ctrl #(.SBOX_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key128(key1),
`ifdef LED_CTRL_ABORT_EN
    .abort(abort1),
`endif
    .load(load1), .busy(busy1), .add_key(add1), .sel_key(sel1),
    .round_en(ren1), .rc(rc1), .round_cnt(rcnt1), .done(done1)
  );

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int cyc,
                             input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic logic [7:0] status5();
    return {3'b000, busy5, done5, add5, sel5, ren5};
  endfunction

  function automatic logic [7:0] status1();
    return {3'b000, busy1, done1, add1, sel1, ren1};
  endfunction

  function automatic logic [7:0] pack(input logic b, input logic d, input logic a,
                                      input logic s, input logic r);
    return {3'b000, b, d, a, s, r};
  endfunction

  // Expected {busy,done,add_key,sel_key,round_en} c cycles after an accepted LED-64 start, S=5.
  function automatic logic [7:0] exp64(input int c);
    return pack(c >= 1 && c <= 161, c == 162,
                (c >= 1 && c <= 160 && (c - 1) % 20 == 0) || c == 161,
                1'b0, c >= 1 && c <= 160 && c % 5 == 0);
  endfunction

  function automatic logic [7:0] exp128(input int c);
    return pack(c >= 1 && c <= 241, c == 242,
                (c >= 1 && c <= 240 && (c - 1) % 20 == 0) || c == 241,
                c >= 1 && c <= 240 && (((c - 1) / 5) / 4) % 2 == 1,
                c >= 1 && c <= 240 && c % 5 == 0);
  endfunction

  initial begin
    rst = 1'b1; start5 = 1'b0; key5 = 1'b0; start1 = 1'b0; key1 = 1'b0;
`ifdef LED_CTRL_ABORT_EN
    abort5 = 1'b0; abort1 = 1'b0;
`endif
    repeat (3) stepCycle();
    checkOutput("rst_status", 0, status5(), 8'h00);
    checkOutput("rst_rc", 0, {2'b00, rc5}, 8'h01);
    checkOutput("rst_round", 0, {2'b00, rcnt5}, 8'h00);
    checkOutput("rst_status1", 0, status1(), 8'h00);
    rst = 1'b0;
    stepCycle();
    checkOutput("idle_status", 0, status5(), 8'h00);
    checkOutput("idle_load", 0, {7'd0, load5}, 8'h00);

    // LED-64, with a stray start and key128 toggle at cycle 50
    $display("[TB] LED-64 S=5");
    key5 = 1'b0; start5 = 1'b1; #1;
    checkOutput("load64", 0, {7'd0, load5}, 8'h01);
    stepCycle();
    start5 = 1'b0;
    for (int c = 1; c <= 162; c++) begin
      checkOutput("st64", c, status5(), exp64(c));
      if (c <= 40 && (c - 1) % 5 == 0) begin
        checkOutput("rc64", c, {2'b00, rc5}, {2'b00, rc_trace[(c - 1) / 5]});
        checkOutput("rcnt64", c, {2'b00, rcnt5}, 8'((c - 1) / 5));
      end
      if (c == 50) begin
        start5 = 1'b1; key5 = 1'b1; #1;
        checkOutput("load_busy", c, {7'd0, load5}, 8'h00);
      end
      if (c < 162) begin
        stepCycle();
        start5 = 1'b0; key5 = 1'b0;
      end
    end

    // LED-128 started in the done cycle
    $display("[TB] LED-128 S=5");
    key5 = 1'b1; start5 = 1'b1; #1;
    checkOutput("load128", 0, {7'd0, load5}, 8'h01);
    stepCycle();
    start5 = 1'b0;
    for (int c = 1; c <= 243; c++) begin
      checkOutput("st128", c, status5(), exp128(c));
      if (c == 50) key5 = 1'b0;
      stepCycle();
    end

    // Reset in the middle of an LED-64 run
    $display("[TB] mid-run reset");
    key5 = 1'b0; start5 = 1'b1;
    stepCycle();
    start5 = 1'b0;
    for (int c = 1; c < 100; c++) stepCycle();
    checkOutput("pre_rst", 100, status5(), exp64(100));
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rst101_status", 101, status5(), 8'h00);
    checkOutput("rst101_rc", 101, {2'b00, rc5}, 8'h01);
    checkOutput("rst101_round", 101, {2'b00, rcnt5}, 8'h00);
    for (int c = 102; c <= 170; c++) begin
      stepCycle();
      checkOutput("post_rst_quiet", c, status5(), 8'h00);
    end
    start5 = 1'b1;
    stepCycle();
    start5 = 1'b0;
    for (int c = 1; c <= 163; c++) begin
      checkOutput("st64b", c, status5(), exp64(c));
      stepCycle();
    end

    // Single-stage datapath, LED-64
    $display("[TB] LED-64 S=1");
    key1 = 1'b0; start1 = 1'b1; #1;
    checkOutput("load1", 0, {7'd0, load1}, 8'h01);
    stepCycle();
    start1 = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      checkOutput("st1", c, status1(),
                  pack(c <= 33, c == 34, (c <= 32 && (c - 1) % 4 == 0) || c == 33,
                       1'b0, c <= 32));
      if (c <= 8)
        checkOutput("rc1", c, {2'b00, rc1}, {2'b00, rc_trace[c - 1]});
      if (c <= 32)
        checkOutput("rcnt1", c, {2'b00, rcnt1}, 8'(c - 1));
      stepCycle();
    end

`ifdef LED_CTRL_ABORT_EN
    $display("[TB] abort");
    start5 = 1'b1;
    stepCycle();
    start5 = 1'b0;
    for (int c = 1; c < 10; c++) stepCycle();
    abort5 = 1'b1;
    stepCycle();
    abort5 = 1'b0;
    checkOutput("abort11", 11, status5(), 8'h00);
    for (int c = 12; c <= 200; c++) begin
      stepCycle();
      checkOutput("abort_quiet", c, status5(), 8'h00);
    end
    start5 = 1'b1; abort5 = 1'b1;
    stepCycle();
    start5 = 1'b0; abort5 = 1'b0;
    checkOutput("start_wins", 1, status5(), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    abort5 = 1'b1;
    stepCycle();
    abort5 = 1'b0;
    checkOutput("abort_clear", 2, status5(), 8'h00);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
